// File: rtl/sym9_gen_pkg.sv
// Shared definitions for the 9-input symmetric-function stimulus generator.
//  - default sizing parameters (vector width, weight width, counter width)
//  - FSM state encodings (IDLE, EMIT)
//  - BINOM: C(9,k) for k = 0..9, the number of vectors emitted per weight
package sym9_gen_pkg;

  localparam int N_DEF        = 9;
  localparam int WEIGHT_W_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  // FSM state encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Vectors per enumeration for N = 9, indexed by weight
  localparam int BINOM [0:9] = '{1, 9, 36, 84, 126, 126, 84, 36, 9, 1};

endpackage

// File: rtl/sym9_next_comb.sv
// Combinational successor function (Gosper's hack): given a vector v, produce
// the next larger vector that has the same number of ones.
//  v      in   N   current vector
//  next_v out  N   next vector of equal popcount (undefined for the last one)
//  carry  out  1   the successor overflowed into bit N; only legal for the
//                  final vector of an enumeration, which is never advanced
module sym9_next_comb #(
  parameter int N = 9
) (
  input  logic [N-1:0] v,
  output logic [N-1:0] next_v,
  output logic         carry
);

  localparam int SH_W = $clog2(N + 1);

  logic [N:0]      v_w;
  logic [N:0]      c;
  logic [N:0]      r;
  logic [N:0]      full;
  logic [SH_W-1:0] sh;

  always_comb begin
    // NOTE: every variable gets a value before any condition so no latch is inferred.
    sh   = '0;
    v_w  = {1'b0, v};
    // c isolates the lowest set bit; r ripples it into the next free zero.
    c    = v_w & (-v_w);
    r    = v_w + c;
    // c is one-hot, so this encoder is log2(c). Scanning high to low lets
    // the lowest set bit be the final assignment.
    for (int i = N; i >= 0; i--) begin
      if (c[i]) sh = SH_W'(i);
    end
    // The bits that moved, right-justified, refill the low end of the vector.
    full   = r | (((r ^ v_w) >> 2) >> sh);
    next_v = full[N-1:0];
    carry  = full[N];
  end

endmodule

// File: rtl/sym9_weight_vector_gen.sv
// Stimulus source for the 9-input symmetric-function benches. On start it
// emits, in ascending order, every N-bit vector with exactly `weight` ones,
// on a valid/ready stream (vec[0] drives input _1 .. vec[8] drives _9).
//  clk       in   1         clock, all state on the rising edge
//  rst       in   1         synchronous active-high reset
//  start     in   1         begin an enumeration (sampled only in IDLE)
//  weight    in   WEIGHT_W  ones per vector, captured with start
//  out_valid out  1         vec is valid
//  out_ready in   1         consumer accepts vec this cycle
//  vec       out  N         current vector
//  out_last  out  1         vec is the final vector of the run
//  busy      out  1         enumeration in progress
//  done      out  1         one-cycle pulse after the last vector is accepted
//  err       out  1         one-cycle pulse: start with weight > N
//  count     out  CNT_W     vectors accepted in the current/last run
module sym9_weight_vector_gen
  import sym9_gen_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        vec,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    count
);

  logic [0:0]          state;
  logic [WEIGHT_W-1:0] weight_q;
  logic [N-1:0]        all_ones;
  logic [N-1:0]        first_vec;
  logic [N-1:0]        last_vec;
  logic [N-1:0]        next_vec;
  logic                next_carry;
  logic                accept;

  sym9_next_comb #(.N(N)) u_next (
    .v      (vec),
    .next_v (next_vec),
    .carry  (next_carry)
  );

  assign all_ones  = '1;
  // Low `weight` bits set; a shift by N or more clears all_ones, giving all-ones.
  assign first_vec = ~(all_ones << weight);
  // Top weight_q bits set; weight 0 yields the all-zero vector.
  assign last_vec  = ~(all_ones >> weight_q);

  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign out_last  = busy & (vec == last_vec);
  assign accept    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      weight_q <= '0;
      vec      <= '0;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (weight > WEIGHT_W'(N)) begin
              err <= 1'b1;
            end else begin
              state    <= EMIT;
              weight_q <= weight;
              vec      <= first_vec;
              count    <= '0;
            end
          end
        end
        EMIT: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (out_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              vec <= next_vec;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every emitted vector carries exactly the captured number of ones.
  a_popcount: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> ($countones(vec) == int'(weight_q)));

  // The successor may only overflow past bit N-1 from the final vector.
  a_no_carry: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_last) |-> !next_carry);

  if (N == 9) begin : g_binom_chk
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      out_valid |-> (int'(count) < BINOM[weight_q]));
  end

endmodule

// File: tb/tb_sym9_weight_vector_gen.sv
// Self-checking bench for sym9_weight_vector_gen. Expected vectors for each
// run are produced by brute-force enumeration of 0..511 and queued when the
// run is started; a monitor pops and compares on every accepted beat.
// Directed checks cover reset, hand-computed vectors, backpressure, error
// handling, mid-run reset and a back-to-back weight sweep.
module tb_sym9_weight_vector_gen;
  import sym9_gen_pkg::*;

  typedef struct {
    logic [8:0] vec;
    logic       last;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] weight;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] vec;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sym9_weight_vector_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vec       (vec),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue every weight-w vector in ascending order; the largest is last.
  task automatic push_run(input int w);
    int idx = 0;
    for (int v = 0; v < 512; v++) begin
      if ($countones(v[8:0]) == w) begin
        exp_t e;
        e.vec  = v[8:0];
        e.last = 1'b0;
        e.idx  = idx;
        sb.push_back(e);
        idx++;
      end
    end
    sb[sb.size()-1].last = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after start was sampled.
  task automatic do_start(input int w);
    if (w <= 9) push_run(w);
    start  = 1'b1;
    weight = 4'(w);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Monitor: compare every accepted beat against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(vec), 32'h3ff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_vec",   32'(vec),      32'(e.vec));
        check("sb_last",  32'(out_last), 32'(e.last));
        check("sb_count", 32'(count),    32'(e.idx));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    weight    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_vec",   32'(vec),       32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_count", 32'(count),     32'd0);

    // 1. weight 3, free-flowing
    do_start(3);
    check("w3_first_vec", 32'(vec), 32'h007);
    check("w3_valid",     32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("w3_second_vec", 32'(vec), 32'h00b);
    @(posedge clk); #1;
    check("w3_third_vec", 32'(vec), 32'h00d);
    wait_done("w3_done");
    check("w3_count", 32'(count), 32'd84);
    check("w3_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("w3_done_pulse_width", 32'(done), 32'd0);

    // 2. weight 0 and weight 9 single-vector runs
    do_start(0);
    check("w0_vec",  32'(vec),      32'h000);
    check("w0_last", 32'(out_last), 32'd1);
    wait_done("w0_done");
    check("w0_count", 32'(count), 32'd1);
    do_start(9);
    check("w9_vec",  32'(vec),      32'h1ff);
    check("w9_last", 32'(out_last), 32'd1);
    wait_done("w9_done");
    check("w9_count", 32'(count), 32'd1);

    // 3. weight out of range
    do_start(10);
    check("w10_err",   32'(err),       32'd1);
    check("w10_valid", 32'(out_valid), 32'd0);
    check("w10_busy",  32'(busy),      32'd0);
    @(posedge clk); #1;
    check("w10_err_pulse", 32'(err),       32'd0);
    check("w10_valid_2",   32'(out_valid), 32'd0);
    check("w10_count",     32'(count),     32'd1);

    // 4. weight 4 with backpressure on the second vector
    do_start(4);
    check("w4_first_vec", 32'(vec), 32'h00f);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("w4_second_vec", 32'(vec), 32'h017);
    repeat (5) begin
      @(posedge clk); #1;
      check("w4_stall_vec",   32'(vec),       32'h017);
      check("w4_stall_count", 32'(count),     32'd1);
      check("w4_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("w4_resume_vec",   32'(vec),   32'h01b);
    check("w4_resume_count", 32'(count), 32'd2);
    wait_done("w4_done");
    check("w4_count", 32'(count), 32'd126);

    // 5. reset in the middle of a weight 5 run
    do_start(5);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        if (count == 8'd40) hit = 1'b1;
        else begin @(posedge clk); #1; end
      end
      check("w5_reach_40", 32'(hit), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("w5_rst_valid", 32'(out_valid), 32'd0);
    check("w5_rst_count", 32'(count),     32'd0);
    check("w5_rst_busy",  32'(busy),      32'd0);
    check("w5_rst_done",  32'(done),      32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("w5_no_done", 32'(done), 32'd0);
    end
    do_start(5);
    check("w5_fresh_vec", 32'(vec), 32'h01f);
    wait_done("w5_done");
    check("w5_count", 32'(count), 32'd126);

    // 6. back-to-back sweep, each start coincident with done
    do_start(0);
    for (int w = 0; w <= 9; w++) begin
      wait_done($sformatf("sweep_done_w%0d", w));
      check($sformatf("sweep_count_w%0d", w), 32'(count), 32'(BINOM[w]));
      if (w < 9) begin
        do_start(w + 1);
        check($sformatf("sweep_busy_w%0d", w + 1), 32'(busy), 32'd1);
      end
    end

    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
